// File: rtl/hex_fmt_if.sv
// Handshake bundle between the word source, the hex formatter and the UART transmit FIFO.
// slave is the formatter side; master is the side that feeds words and drains bytes.
interface hex_fmt_if #(
    parameter int WORD_BITS = 32
);
    logic                 i_valid;
    logic [WORD_BITS-1:0] i_word;
    logic                 o_ready;
    logic                 o_valid;
    logic [7:0]           o_data;
    logic                 i_ready;
    logic                 o_busy;
    logic [15:0]          o_lines;

    modport slave (
        input  i_valid, i_word, i_ready,
        output o_ready, o_valid, o_data, o_busy, o_lines
    );

    modport master (
        output i_valid, i_word, i_ready,
        input  o_ready, o_valid, o_data, o_busy, o_lines
    );
endinterface

// File: rtl/hex_fmt.sv
// Prints one word per line as ASCII hex (MSB nibble first) followed by CR LF or LF.
// Latency: first byte valid 1 cycle after word accept, then one byte per cycle.
// Backpressure: byte held stable while !i_ready; no new word taken until the line ends.
module hex_fmt #(
    parameter int WORD_BITS = 32,
    parameter bit UPPERCASE = 1'b1,
    parameter bit EOL_CRLF  = 1'b1
) (
    input  logic     clk,
    input  logic     i_reset_n,
    hex_fmt_if.slave bus
);
    localparam int NIBS  = WORD_BITS / 4;
    localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEX  = 2'd1,
        CR   = 2'd2,
        LF   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [7:0]           data_q, data_d;
    logic [15:0]          lines_q, lines_d;

    logic                 xfer;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [WORD_BITS-1:0] word_shift;

    function automatic logic [7:0] nib2asc(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        // 0x37 + 10 = 'A', 0x57 + 10 = 'a'
        return (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, n};
    endfunction

    assign xfer       = valid_q && bus.i_ready;
    assign cnt_nxt    = cnt_q + CNT_W'(1);
    assign word_shift = word_q << {cnt_nxt, 2'b00};

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        lines_d = lines_q;

        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    word_d  = bus.i_word;
                    cnt_d   = '0;
                    state_d = HEX;
                    valid_d = 1'b1;
                    data_d  = nib2asc(bus.i_word[WORD_BITS-1 -: 4]);
                end
            end
            HEX: begin
                if (xfer) begin
                    if (cnt_q == LAST_NIB) begin
                        state_d = EOL_CRLF ? CR : LF;
                        data_d  = EOL_CRLF ? 8'h0D : 8'h0A;
                    end else begin
                        cnt_d  = cnt_nxt;
                        data_d = nib2asc(word_shift[WORD_BITS-1 -: 4]);
                    end
                end
            end
            CR: begin
                if (xfer) begin
                    state_d = LF;
                    data_d  = 8'h0A;
                end
            end
            LF: begin
                // Returning through IDLE costs one cycle before the next word is taken.
                if (xfer) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    lines_d = lines_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            lines_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            lines_q <= lines_d;
        end
    end

    assign bus.o_ready = (state_q == IDLE);
    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_lines = lines_q;
endmodule

// File: tb/tb_hex_fmt.sv
// Scoreboard bench: drivers push expected bytes (with optional expected cycle), monitors pop on each transfer.
// u0 uses defaults; u1 uses lowercase letters with LF-only line endings.
module tb_hex_fmt;
    logic clk = 1'b0;
    logic i_reset_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    hex_fmt_if #(.WORD_BITS(32)) f0 ();
    hex_fmt_if #(.WORD_BITS(32)) f1 ();

    hex_fmt #(.WORD_BITS(32), .UPPERCASE(1'b1), .EOL_CRLF(1'b1)) u0 (
        .clk(clk), .i_reset_n(i_reset_n), .bus(f0.slave)
    );
    hex_fmt #(.WORD_BITS(32), .UPPERCASE(1'b0), .EOL_CRLF(1'b0)) u1 (
        .clk(clk), .i_reset_n(i_reset_n), .bus(f1.slave)
    );

    typedef struct {
        logic [7:0] b;
        int         c;   // expected monitor cycle, -1 = any
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // bytes are left-aligned in the 80-bit vector
    task automatic exp_push(input int which, input logic [79:0] bytes, input int n, input int c0);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.b = bytes[79-8*i -: 8];
            e.c = (c0 < 0) ? -1 : c0 + i;
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (f0.o_valid && f0.i_ready) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_byte", {24'h0, f0.o_data}, 32'hFFFF_FFFF);
            end else begin
                e = q0.pop_front();
                chk("u0_byte", {24'h0, f0.o_data}, {24'h0, e.b});
                if (e.c >= 0) chk("u0_byte_cycle", cyc, e.c);
            end
        end else if (f0.o_valid && !f0.i_ready && q0.size() != 0) begin
            chk("u0_hold", {24'h0, f0.o_data}, {24'h0, q0[0].b});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (f1.o_valid && f1.i_ready) begin
            if (q1.size() == 0) begin
                chk("u1_unexpected_byte", {24'h0, f1.o_data}, 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                chk("u1_byte", {24'h0, f1.o_data}, {24'h0, e.b});
                if (e.c >= 0) chk("u1_byte_cycle", cyc, e.c);
            end
        end
    end

    task automatic send(input int which, input logic [31:0] w, output int c);
        int t = 0;
        while (((which == 0) ? !f0.o_ready : !f1.o_ready) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 100) chk("send_ready_timeout", 32'(t), 32'd0);
        c = cyc;
        if (which == 0) begin f0.i_valid = 1'b1; f0.i_word = w; end
        else            begin f1.i_valid = 1'b1; f1.i_word = w; end
        @(posedge clk); #1;
        f0.i_valid = 1'b0;
        f1.i_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || f0.o_busy || f1.o_busy) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 200) chk("drain_timeout", 32'(t), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        f0.i_valid = 1'b0; f0.i_word = '0; f0.i_ready = 1'b1;
        f1.i_valid = 1'b0; f1.i_word = '0; f1.i_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", {31'h0, f0.o_valid}, 32'd0);
        chk("rst_o_data",  {24'h0, f0.o_data},  32'h00);
        chk("rst_o_lines", {16'h0, f0.o_lines}, 32'd0);
        i_reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_o_ready", {31'h0, f0.o_ready}, 32'd1);
        chk("rel_o_busy",  {31'h0, f0.o_busy},  32'd0);

        // DEADBEEF at full rate, timed
        send(0, 32'hDEADBEEF, c);
        exp_push(0, 80'h44_45_41_44_42_45_45_46_0D_0A, 10, c + 1);
        chk("line_busy", {31'h0, f0.o_busy}, 32'd1);
        drain();
        chk("lines_after_1", {16'h0, f0.o_lines}, 32'd1);

        // stall 3 cycles while the 4th byte (0x44) is presented
        send(0, 32'hDEADBEEF, c);
        exp_push(0, 80'h44_45_41_44_42_45_45_46_0D_0A, 10, -1);
        repeat (3) @(posedge clk);
        #1 f0.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 f0.i_ready = 1'b1;
        drain();
        chk("lines_after_2", {16'h0, f0.o_lines}, 32'd2);

        // lowercase, LF only
        send(1, 32'h00C0FFEE, c);
        exp_push(1, 80'h30_30_63_30_66_66_65_65_0A_00, 9, c + 1);
        drain();
        chk("u1_lines", {16'h0, f1.o_lines}, 32'd1);

        // reset after the 4th byte of a line
        send(0, 32'hDEADBEEF, c);
        exp_push(0, 80'h44_45_41_44_00_00_00_00_00_00, 4, c + 1);
        repeat (4) @(posedge clk);
        #1 i_reset_n = 1'b0;
        #1;
        chk("mid_rst_o_valid", {31'h0, f0.o_valid}, 32'd0);
        chk("mid_rst_o_lines", {16'h0, f0.o_lines}, 32'd0);
        chk("mid_rst_o_busy",  {31'h0, f0.o_busy},  32'd0);
        @(posedge clk); #1;
        i_reset_n = 1'b1;
        chk("mid_rel_o_ready", {31'h0, f0.o_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        send(0, 32'h12345678, c);
        exp_push(0, 80'h31_32_33_34_35_36_37_38_0D_0A, 10, c + 1);
        drain();
        chk("lines_after_rst", {16'h0, f0.o_lines}, 32'd1);

        // i_valid held across two words
        c = cyc;
        f0.i_valid = 1'b1;
        f0.i_word  = 32'hCAFEF00D;
        exp_push(0, 80'h43_41_46_45_46_30_30_44_0D_0A, 10, c + 1);
        exp_push(0, 80'h30_31_32_33_41_42_43_44_0D_0A, 10, c + 12);
        @(posedge clk); #1;
        f0.i_word = 32'h0123ABCD;
        for (int i = 0; i < 10; i++) begin
            chk("b2b_ready_low", {31'h0, f0.o_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("b2b_ready_high", {31'h0, f0.o_ready}, 32'd1);
        @(posedge clk); #1;
        f0.i_valid = 1'b0;
        drain();
        chk("lines_after_b2b", {16'h0, f0.o_lines}, 32'd3);

        // line counter wrap
        force u0.lines_q = 16'hFFFF;
        @(posedge clk); #1;
        release u0.lines_q;
        @(posedge clk); #1;
        chk("preload_lines", {16'h0, f0.o_lines}, 32'hFFFF);
        send(0, 32'h00000000, c);
        exp_push(0, 80'h30_30_30_30_30_30_30_30_0D_0A, 10, c + 1);
        drain();
        chk("lines_wrap", {16'h0, f0.o_lines}, 32'h0000);

        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hex_fmt.md
HEX_FMT -- requirements
Module: hex_fmt

Interface
REQ-001 SHALL have parameter WORD_BITS, default 32, input word width; must be a nonzero multiple of 4.
REQ-002 SHALL have parameter UPPERCASE, default 1; 1 emits hex letters A-F, 0 emits a-f.
REQ-003 SHALL have parameter EOL_CRLF, default 1; 1 terminates each line with CR LF, 0 with LF only.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_valid  input  1  upstream word valid.
REQ-007 SHALL have port i_word  input  WORD_BITS  upstream word to print.
REQ-008 SHALL have port o_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port o_valid  output  1  o_data holds a byte for the UART transmit stage.
REQ-010 SHALL have port o_data  output  8  ASCII byte.
REQ-011 SHALL have port i_ready  input  1  downstream accepts o_data this cycle (tied to not-full of the transmit FIFO).
REQ-012 SHALL have port o_busy  output  1  a line is in progress.
REQ-013 SHALL have port o_lines  output  16  count of completed lines.

Function
REQ-014 SHALL implement states IDLE, HEX, CR, LF.
REQ-015 SHALL drive o_ready = 1 only in IDLE; word accept = i_valid && o_ready.
REQ-016 SHALL, on word accept, register i_word, clear the nibble counter, and enter HEX.
REQ-017 SHALL ignore i_valid and i_word outside IDLE; upstream holds its word until accept.
REQ-018 SHALL define byte transfer as o_valid && i_ready at a rising edge.
REQ-019 SHALL register o_valid and o_data, with o_valid asserted the cycle after word accept (latency 1).
REQ-020 SHALL hold o_data and o_valid stable while o_valid && !i_ready.
REQ-021 SHALL emit nibbles MSB first: nibble k = word[WORD_BITS-1-4k -: 4], for k = 0 .. WORD_BITS/4-1.
REQ-022 SHALL map nibble 0-9 to 0x30-0x39, and 10-15 to 0x41-0x46 if UPPERCASE=1, else 0x61-0x66.
REQ-023 SHALL advance the nibble counter on each transfer in HEX, with counter width clog2(WORD_BITS/4) bits, minimum 1.
REQ-024 SHALL, on transfer of the last nibble, go to CR if EOL_CRLF=1, else to LF.
REQ-025 SHALL emit 0x0D in CR and 0x0A in LF, each advancing on its transfer.
REQ-026 SHALL, on LF transfer, return to IDLE, deassert o_valid, and increment o_lines modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-027 SHALL NOT accept a new word in the same cycle as LF transfer; o_ready rises the following cycle.
REQ-028 SHALL sustain one byte per cycle while i_ready=1; a line is WORD_BITS/4 + 2 bytes, or +1 when EOL_CRLF=0.
REQ-029 SHALL drive o_busy = 1 in every state except IDLE.

Reset
REQ-030 SHALL, while i_reset_n=0, asynchronously force state IDLE, o_valid=0, o_data=0x00, o_lines=0, and the nibble counter and word register to 0.
REQ-031 SHALL abort any partial line on reset; no further bytes of that line are emitted after release.
REQ-032 SHALL have o_ready=1 and o_busy=0 in the first cycle after reset release.

Verification
REQ-033 SHALL verify: i_word=0xDEADBEEF accepted, i_ready=1 -> bytes 44 45 41 44 42 45 45 46 0D 0A on 10 consecutive cycles starting 1 cycle after accept; o_lines 0->1.
REQ-034 SHALL verify: same word with i_ready low for 3 cycles on byte 3 -> 0x44 held for those cycles, sequence unchanged, no byte lost or duplicated.
REQ-035 SHALL verify: UPPERCASE=0, EOL_CRLF=0, i_word=0x00C0FFEE -> 30 30 63 30 66 66 65 65 0A.
REQ-036 SHALL verify: i_reset_n pulsed low after the 4th byte of a line -> o_valid=0 immediately, o_lines=0, and the next accepted word 0x12345678 yields 31 32 33 34 35 36 37 38 0D 0A.
REQ-037 SHALL verify: i_valid held high across two words -> second word accepted exactly 1 cycle after first LF transfer; o_ready=0 for the whole first line.
REQ-038 SHALL verify: o_lines preloaded to 0xFFFF by 65535 lines, or by forcing in simulation -> next completed line gives 0x0000.
